seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for a DIGITS-wide common-cathode 7-segment display.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_hex_decode.sv | 17 +
 rtl/seg_scan_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan controller:
//     - segment bit positions inside the {dp,g,f,e,d,c,b,a} bus
//     - hex font table (bit 0 = segment a ... bit 6 = segment g)
//     - slot state enum used by the scan FSM
//   No ports (package).
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } slot_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// ----------------------------------------------------------------------------
// seg_hex_decode
//   Combinational nibble -> 7-segment pattern lookup.
//   Ports:
//     nibble    in  4   hex digit value
//     segments  out 7   {g,f,e,d,c,b,a}, active-high
// ----------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_FONT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a DIGITS-wide common-cathode
//   7-segment display. A hex value written over a valid/ready port lands in
//   a shadow register and is copied to the display register only at a frame
//   boundary (or immediately while scanning is disabled), so a frame never
//   shows a mix of old and new digits. Each digit slot starts with a dark
//   dead-time to avoid ghosting between digits.
//   Ports:
//     clk         in   1          system clock
//     rst         in   1          synchronous reset, active-high
//     ena         in   1          scan enable (low = dark, scan frozen)
//     wr_valid    in   1          write request
//     wr_data     in   4*DIGITS   hex value, nibble i -> digit i
//     wr_ready    out  1          write port can accept
//     lz_blank    in   1          suppress leading zeros
//     dp_mask     in   DIGITS     decimal point per digit (live)
//     seg_out     out  8          {dp,g,f,e,d,c,b,a}, registered
//     dig_en      out  DIGITS     one-hot digit enable, registered
//     frame_done  out  1          pulse during the last cycle of a frame
// ----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wr_valid,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic                  wr_ready,
    input  logic                  lz_blank,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    slot_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [4*DIGITS-1:0]  shadow, shadow_next;
    logic [4*DIGITS-1:0]  disp, disp_next;
    logic                 pending, pending_next;

    logic                 slot_end;
    logic                 frame_end;
    logic                 accept;
    logic                 transfer;

    logic [3:0]           nibble;
    logic [6:0]           font;
    logic                 dp_bit;
    logic                 blank_digit;
    logic                 upper_zero;
    logic [DIGITS-1:0]    lead_zero;

    logic [7:0]           seg_next;
    logic [DIGITS-1:0]    dig_next;
    logic                 frame_next;

    assign wr_ready = ~pending;

    // Next-state logic: prescaler, slot phase, digit index and the
    // shadow/display handoff. Dropping ena parks the slot at the start of
    // its dead-time but keeps idx, and flushes any pending write so the
    // writer is never left waiting on a frozen scan.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx;
        shadow_next  = shadow;
        disp_next    = disp;
        pending_next = pending;

        slot_end  = (state == ST_DRIVE) && (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        accept    = wr_valid && !pending;
        transfer  = pending && (frame_end || !ena);

        if (!ena) begin
            cnt_next   = '0;
            state_next = ST_BLANK;
        end else if (slot_end) begin
            cnt_next   = '0;
            state_next = ST_BLANK;
            idx_next   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt_next   = cnt + CNT_W'(1);
            state_next = (cnt_next >= CNT_BLANK) ? ST_DRIVE : ST_BLANK;
        end

        if (transfer) begin
            disp_next    = shadow;
            pending_next = 1'b0;
        end
        if (accept) begin
            shadow_next  = wr_data;
            pending_next = 1'b1;
        end
    end

    // Picks the nibble and decimal point of the digit about to be shown and
    // works out whether it is a leading zero (it and every digit above it
    // are zero). Digit 0 is never treated as leading.
    always_comb begin
        nibble      = '0;
        dp_bit      = 1'b0;
        blank_digit = 1'b0;
        upper_zero  = 1'b1;
        lead_zero   = '0;

        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero && (disp_next[4*i +: 4] == 4'h0);
            lead_zero[i] = upper_zero;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nibble      = disp_next[4*i +: 4];
                dp_bit      = dp_mask[i];
                blank_digit = lz_blank && (i != 0) && lead_zero[i];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble   (nibble),
        .segments (font)
    );

    // Output values are derived from the next state so the registered
    // outputs move on the same edge as the FSM. Every slot opens dark, so
    // dig_en and the segment bus always switch digits together.
    always_comb begin
        seg_next   = '0;
        dig_next   = '0;
        frame_next = 1'b0;

        if (state_next == ST_DRIVE) begin
            dig_next         = DIGITS'(1) << idx_next;
            seg_next[SEG_DP] = dp_bit;
            if (!blank_digit) begin
                seg_next[SEG_G:SEG_A] = font;
            end
        end

        frame_next = ena && (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            seg_out    <= '0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            shadow     <= shadow_next;
            disp       <= disp_next;
            pending    <= pending_next;
            seg_out    <= seg_next;
            dig_en     <= dig_next;
            frame_done <= frame_next;
        end
    end

endmodule
